// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle sequencer: states, instruction
// classes, opcodes, ALUop codes and write-back source selects.
package multicycle_control_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    typedef enum logic [2:0] {
        CLS_R   = 3'd0,
        CLS_I   = 3'd1,
        CLS_LW  = 3'd2,
        CLS_SW  = 3'd3,
        CLS_JAL = 3'd4
    } class_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALUOP_JUMP  = 3'b000;
    localparam logic [2:0] ALUOP_SHIFT = 3'b001;
    localparam logic [2:0] ALUOP_LOAD  = 3'b010;
    localparam logic [2:0] ALUOP_STORE = 3'b011;
    localparam logic [2:0] ALUOP_ARITH = 3'b100;

    localparam logic [1:0] RES_ALU = 2'b00;
    localparam logic [1:0] RES_MEM = 2'b01;
    localparam logic [1:0] RES_PC4 = 2'b10;

    function automatic logic is_shift(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b101);
    endfunction

endpackage

// File: rtl/multicycle_control_ctrl_aluop_decode.sv
// Maps the registered instruction class plus funct3 to the ALUop code
// consumed by the ALU control decoder.
module ctrl_aluop_decode
    import multicycle_control_pkg::*;
(
    input  logic [2:0] cls,
    input  logic [2:0] funct3,
    output logic [2:0] aluop
);

    always_comb begin
        aluop = ALUOP_JUMP;
        case (cls)
            CLS_R:   aluop = ALUOP_ARITH;
            CLS_I:   aluop = is_shift(funct3) ? ALUOP_SHIFT : ALUOP_ARITH;
            CLS_LW:  aluop = ALUOP_LOAD;
            CLS_SW:  aluop = ALUOP_STORE;
            CLS_JAL: aluop = ALUOP_JUMP;
            default: aluop = ALUOP_JUMP;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer with a req/ready memory
// handshake guarded by a wait-cycle timeout.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_we,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       pc_src,
    output logic       reg_write,
    output logic [1:0] result_src,
    output logic       alu_src_a,
    output logic       alu_src_b,
    output logic [2:0] ALUop,
    output logic       illegal_op,
    output logic       bus_err
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_e     state_q, state_d;
    class_e     cls_q, cls_d;
    class_e     dec_cls;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] exec_aluop;
    logic       legal;
    logic       mem_phase;
    logic       timeout;

    ctrl_aluop_decode u_aluop_decode (
        .cls    (cls_q),
        .funct3 (funct3),
        .aluop  (exec_aluop)
    );

    always_comb begin
        legal   = 1'b1;
        dec_cls = CLS_R;
        case (opcode)
            OP_R:    dec_cls = CLS_R;
            OP_I:    dec_cls = CLS_I;
            OP_LW:   dec_cls = CLS_LW;
            OP_SW:   dec_cls = CLS_SW;
            OP_JAL:  dec_cls = CLS_JAL;
            default: legal   = 1'b0;
        endcase
    end

    // A ready in the timeout cycle still completes the transfer.
    assign mem_phase = (state_q == S_FETCH) || (state_q == S_MEM);
    assign timeout   = mem_phase && !mem_ready && (cnt_q == TIMEOUT_CNT);

    always_comb begin
        state_d    = state_q;
        cls_d      = cls_q;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        reg_write  = 1'b0;
        result_src = RES_ALU;
        alu_src_a  = 1'b0;
        alu_src_b  = 1'b0;
        ALUop      = ALUOP_JUMP;
        illegal_op = 1'b0;
        bus_err    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    mem_req = !timeout;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        bus_err  = 1'b1;
                    end
                end
                S_DECODE: begin
                    if (legal) begin
                        cls_d   = dec_cls;
                        state_d = S_EXEC;
                    end else begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                end
                S_EXEC: begin
                    ALUop = exec_aluop;
                    case (cls_q)
                        CLS_JAL: begin
                            alu_src_a  = 1'b1;
                            alu_src_b  = 1'b1;
                            pc_write   = 1'b1;
                            pc_src     = 1'b1;
                            reg_write  = 1'b1;
                            result_src = RES_PC4;
                            state_d    = S_FETCH;
                        end
                        CLS_R: state_d = S_WB;
                        CLS_I: begin
                            alu_src_b = 1'b1;
                            state_d   = S_WB;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_src_b = 1'b1;
                            state_d   = S_MEM;
                        end
                        default: state_d = S_FETCH;
                    endcase
                end
                S_MEM: begin
                    mem_req = !timeout;
                    iord    = 1'b1;
                    mem_we  = !timeout && (cls_q == CLS_SW);
                    if (mem_ready) begin
                        state_d = (cls_q == CLS_SW) ? S_FETCH : S_WB;
                    end else if (timeout) begin
                        bus_err = 1'b1;
                        state_d = S_FETCH;
                    end
                end
                S_WB: begin
                    reg_write  = 1'b1;
                    result_src = (cls_q == CLS_LW) ? RES_MEM : RES_ALU;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q || timeout) begin
            cnt_d = '0;
        end else if (mem_req && !mem_ready) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            cls_q   <= CLS_R;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-cycle expected outputs are
// queued with their stimulus, then replayed and compared cycle by cycle.
module tb_multicycle_control;

    localparam logic [6:0] R_OP   = 7'b0110011;
    localparam logic [6:0] I_OP   = 7'b0010011;
    localparam logic [6:0] LW_OP  = 7'b0000011;
    localparam logic [6:0] SW_OP  = 7'b0100011;
    localparam logic [6:0] JAL_OP = 7'b1101111;
    localparam logic [6:0] BAD_OP = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic       mem_ready = 1'b0;
    logic       mem_req, mem_we, iord, ir_write, pc_write, pc_src;
    logic       reg_write, alu_src_a, alu_src_b, illegal_op, bus_err;
    logic [1:0] result_src;
    logic [2:0] aluop;

    multicycle_control #(.MEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode     (opcode),
        .funct3     (funct3),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .reg_write  (reg_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .ALUop      (aluop),
        .illegal_op (illegal_op),
        .bus_err    (bus_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       pc_src;
        logic       reg_write;
        logic [1:0] result_src;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [2:0] aluop;
        logic       illegal_op;
        logic       bus_err;
    } outs_t;

    typedef struct packed {
        logic       rst;
        logic       rdy;
        logic [6:0] op;
        logic [2:0] f3;
        outs_t      o;
    } stim_t;

    stim_t sb[$];
    int n_checks = 0;
    int n_fail   = 0;

    function automatic outs_t sample();
        outs_t o;
        o.st         = dut.state_q;
        o.mem_req    = mem_req;
        o.mem_we     = mem_we;
        o.iord       = iord;
        o.ir_write   = ir_write;
        o.pc_write   = pc_write;
        o.pc_src     = pc_src;
        o.reg_write  = reg_write;
        o.result_src = result_src;
        o.alu_src_a  = alu_src_a;
        o.alu_src_b  = alu_src_b;
        o.aluop      = aluop;
        o.illegal_op = illegal_op;
        o.bus_err    = bus_err;
        return o;
    endfunction

    function automatic outs_t o_zero(input logic [2:0] st);
        outs_t o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic outs_t o_fetch(input logic rdy);
        outs_t o = o_zero(3'd0);
        o.mem_req  = 1'b1;
        o.ir_write = rdy;
        o.pc_write = rdy;
        return o;
    endfunction

    function automatic outs_t o_dec(input logic ill);
        outs_t o = o_zero(3'd1);
        o.illegal_op = ill;
        return o;
    endfunction

    function automatic outs_t o_exec(input logic [2:0] op, input logic b);
        outs_t o = o_zero(3'd2);
        o.aluop     = op;
        o.alu_src_b = b;
        return o;
    endfunction

    function automatic outs_t o_jal();
        outs_t o = o_exec(3'b000, 1'b1);
        o.alu_src_a  = 1'b1;
        o.pc_write   = 1'b1;
        o.pc_src     = 1'b1;
        o.reg_write  = 1'b1;
        o.result_src = 2'b10;
        return o;
    endfunction

    function automatic outs_t o_mem(input logic we);
        outs_t o = o_zero(3'd3);
        o.mem_req = 1'b1;
        o.iord    = 1'b1;
        o.mem_we  = we;
        return o;
    endfunction

    function automatic outs_t o_wb(input logic [1:0] rs);
        outs_t o = o_zero(3'd4);
        o.reg_write  = 1'b1;
        o.result_src = rs;
        return o;
    endfunction

    function automatic outs_t o_tmo(input logic [2:0] st, input logic io);
        outs_t o = o_zero(st);
        o.iord    = io;
        o.bus_err = 1'b1;
        return o;
    endfunction

    task automatic push(input logic r, input logic rdy, input logic [6:0] op,
                        input logic [2:0] f3, input outs_t o);
        stim_t e;
        e.rst = r;
        e.rdy = rdy;
        e.op  = op;
        e.f3  = f3;
        e.o   = o;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b1, 1'b1, R_OP, 3'd0, o_zero(3'd0));
        push(1'b1, 1'b0, R_OP, 3'd0, o_zero(3'd0));
        push(1'b0, 1'b0, R_OP, 3'd0, o_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_r_type();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b0, 1'b1, R_OP, 3'd0, o_fetch(1'b1));
        push(1'b0, 1'b1, R_OP, 3'd0, o_dec(1'b0));
        push(1'b0, 1'b1, R_OP, 3'd0, o_exec(3'b100, 1'b0));
        push(1'b0, 1'b1, R_OP, 3'd0, o_wb(2'b00));
        push(1'b0, 1'b0, R_OP, 3'd0, o_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL r_type cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_i_type();
        stim_t      e;
        outs_t      got;
        int         cyc = 0;
        logic [2:0] f3s[4] = '{3'b000, 3'b001, 3'b101, 3'b100};
        logic [2:0] ops[4] = '{3'b100, 3'b001, 3'b001, 3'b100};
        for (int k = 0; k < 4; k++) begin
            push(1'b0, 1'b1, I_OP, f3s[k], o_fetch(1'b1));
            push(1'b0, 1'b1, I_OP, f3s[k], o_dec(1'b0));
            push(1'b0, 1'b1, I_OP, f3s[k], o_exec(ops[k], 1'b1));
            push(1'b0, 1'b1, I_OP, f3s[k], o_wb(2'b00));
        end
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL i_type cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_lw_wait();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b0, 1'b1, LW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_exec(3'b010, 1'b1));
        for (int k = 0; k < 3; k++)
            push(1'b0, 1'b0, LW_OP, 3'd2, o_mem(1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_mem(1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_wb(2'b01));
        push(1'b0, 1'b0, LW_OP, 3'd2, o_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL lw_wait cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_sw_jal_illegal();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b0, 1'b1, SW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_exec(3'b011, 1'b1));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_mem(1'b1));
        push(1'b0, 1'b1, JAL_OP, 3'd0, o_fetch(1'b1));
        push(1'b0, 1'b1, JAL_OP, 3'd0, o_dec(1'b0));
        push(1'b0, 1'b1, JAL_OP, 3'd0, o_jal());
        push(1'b0, 1'b1, BAD_OP, 3'd0, o_fetch(1'b1));
        push(1'b0, 1'b1, BAD_OP, 3'd0, o_dec(1'b1));
        push(1'b0, 1'b0, BAD_OP, 3'd0, o_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL sw_jal_ill cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_timeout();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b0, 1'b1, SW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_exec(3'b011, 1'b1));
        for (int k = 0; k < 4; k++)
            push(1'b0, 1'b0, SW_OP, 3'd2, o_mem(1'b1));
        push(1'b0, 1'b0, SW_OP, 3'd2, o_tmo(3'd3, 1'b1));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_exec(3'b011, 1'b1));
        for (int k = 0; k < 4; k++)
            push(1'b0, 1'b0, SW_OP, 3'd2, o_mem(1'b1));
        push(1'b0, 1'b1, SW_OP, 3'd2, o_mem(1'b1));
        push(1'b0, 1'b0, SW_OP, 3'd2, o_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL timeout cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_mid_reset();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b0, 1'b1, LW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_exec(3'b010, 1'b1));
        push(1'b0, 1'b0, LW_OP, 3'd2, o_mem(1'b0));
        push(1'b0, 1'b0, LW_OP, 3'd2, o_mem(1'b0));
        push(1'b1, 1'b0, LW_OP, 3'd2, o_zero(3'd3));
        for (int k = 0; k < 4; k++)
            push(1'b0, 1'b0, LW_OP, 3'd2, o_fetch(1'b0));
        push(1'b0, 1'b0, LW_OP, 3'd2, o_tmo(3'd0, 1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_exec(3'b010, 1'b1));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_mem(1'b0));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_wb(2'b01));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL mid_reset cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back();
        stim_t e;
        outs_t got;
        int    cyc = 0;
        push(1'b0, 1'b1, BAD_OP, 3'd0, o_fetch(1'b1));
        push(1'b0, 1'b1, BAD_OP, 3'd0, o_dec(1'b1));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_fetch(1'b1));
        push(1'b0, 1'b1, LW_OP, 3'd2, o_dec(1'b0));
        push(1'b0, 1'b1, BAD_OP, 3'd1, o_exec(3'b010, 1'b1));
        push(1'b0, 1'b1, JAL_OP, 3'd1, o_mem(1'b0));
        push(1'b0, 1'b1, SW_OP, 3'd1, o_wb(2'b01));
        push(1'b0, 1'b1, JAL_OP, 3'd0, o_fetch(1'b1));
        push(1'b0, 1'b1, JAL_OP, 3'd0, o_dec(1'b0));
        push(1'b0, 1'b1, R_OP, 3'd5, o_jal());
        push(1'b0, 1'b0, R_OP, 3'd0, o_fetch(1'b0));
        while (sb.size() > 0) begin
            e = sb.pop_front();
            @(negedge clk);
            rst = e.rst; mem_ready = e.rdy; opcode = e.op; funct3 = e.f3;
            #2;
            got = sample();
            n_checks++;
            if (got !== e.o) begin
                n_fail++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", cyc, got, e.o);
            end
            cyc++;
        end
    endtask

    initial begin
        test_reset();
        test_r_type();
        test_i_type();
        test_lw_wait();
        test_sw_jal_illegal();
        test_timeout();
        test_mid_reset();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
